// File: rtl/div_pkg.sv
// Shared definitions for the divider round-robin arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package div_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DD_W    = 32;
    localparam int DEF_DV_W    = 16;
    localparam int DEF_Q_W     = 16;
    localparam int DEF_TMO_CYC = 255;

    // Sequencer states for the divider's four-phase go/done handshake.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GO_HI   = 3'd1,
        WAIT_DN = 3'd2,
        GO_LO   = 3'd3,
        RESP    = 3'd4
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requesting index strictly after ptr_i, modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; vld_o low when no request is present.
// Ports: req_i (request vector), ptr_i (last winner), win_o (winner index), vld_o (any request).
module rr_pick
    import div_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [$clog2(N_REQ)-1:0] win_o,
    output logic                     vld_o
);

    localparam int IDX_W = $clog2(N_REQ);

    int idx;

    // Scan from farthest to nearest so the nearest requester after ptr_i wins last.
    always_comb begin
        win_o = ptr_i;
        vld_o = 1'b0;
        idx   = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (req_i[IDX_W'(idx)]) begin
                win_o = IDX_W'(idx);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_rr_arbiter.sv
// Round-robin sharing of one go/done sequential divider among N_REQ clients; divide-by-zero short-circuit, per-phase timeout.
// Latency: grant to ack is one cycle for dv==0, otherwise 3 cycles plus the divider's own latency.
// Backpressure: requests are level and held until ack; new grants wait in IDLE until div_done is high.
// Ports: clk/rst_n; client side req, dd_in, dv_in, ack, q_out, dz_out, err_out, busy;
//        divider side div_go, div_dd, div_dv, div_done, div_q.
module div_rr_arbiter
    import div_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DD_W    = DEF_DD_W,
    parameter int DV_W    = DEF_DV_W,
    parameter int Q_W     = DEF_Q_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DD_W-1:0] dd_in,
    input  logic [N_REQ*DV_W-1:0] dv_in,
    output logic [N_REQ-1:0]      ack,
    output logic [Q_W-1:0]        q_out,
    output logic                  dz_out,
    output logic                  err_out,
    output logic                  busy,
    output logic                  div_go,
    output logic [DD_W-1:0]       div_dd,
    output logic [DV_W-1:0]       div_dv,
    input  logic                  div_done,
    input  logic [Q_W-1:0]        div_q
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   cur_id_q, cur_id_d;
    logic [DD_W-1:0]    dd_q, dd_d;
    logic [DV_W-1:0]    dv_q, dv_d;
    logic [Q_W-1:0]     res_q_q, res_q_d;      // quotient waiting to be presented
    logic               res_err_q, res_err_d;  // pending result came from a timeout
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [Q_W-1:0]     qo_q, qo_d;
    logic               dz_q, dz_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   pick_win;
    logic               pick_vld;
    logic [DD_W-1:0]    dd_sel;
    logic [DV_W-1:0]    dv_sel;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .win_o (pick_win),
        .vld_o (pick_vld)
    );

    assign dd_sel = dd_in[int'(pick_win)*DD_W +: DD_W];
    assign dv_sel = dv_in[int'(pick_win)*DV_W +: DV_W];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_id_d  = cur_id_q;
        dd_d      = dd_q;
        dv_d      = dv_q;
        res_q_d   = res_q_q;
        res_err_d = res_err_q;
        tmo_d     = tmo_q;
        qo_d      = qo_q;
        dz_d      = dz_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                // div_done low here means the divider still owes a previous (possibly aborted) op.
                if (pick_vld && div_done) begin
                    rr_ptr_d = pick_win;
                    cur_id_d = pick_win;
                    dd_d     = dd_sel;
                    dv_d     = dv_sel;
                    if (dv_sel == '0) begin
                        qo_d    = '0;
                        dz_d    = 1'b1;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        tmo_d   = '0;
                        state_d = GO_HI;
                    end
                end
            end
            GO_HI: begin
                if (!div_done) begin
                    tmo_d   = '0;
                    state_d = WAIT_DN;
                end else if (tmo_q == TMO_LAST) begin
                    res_q_d   = '0;
                    res_err_d = 1'b1;
                    state_d   = GO_LO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_DN: begin
                if (div_done) begin
                    res_q_d   = div_q;
                    res_err_d = 1'b0;
                    state_d   = GO_LO;
                end else if (tmo_q == TMO_LAST) begin
                    res_q_d   = '0;
                    res_err_d = 1'b1;
                    state_d   = GO_LO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            GO_LO: begin
                // Result registers load here so they change exactly in the ack cycle.
                qo_d    = res_q_q;
                dz_d    = 1'b0;
                err_d   = res_err_q;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= IDX_W'(N_REQ - 1);
            cur_id_q  <= '0;
            dd_q      <= '0;
            dv_q      <= '0;
            res_q_q   <= '0;
            res_err_q <= 1'b0;
            tmo_q     <= '0;
            qo_q      <= '0;
            dz_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_id_q  <= cur_id_d;
            dd_q      <= dd_d;
            dv_q      <= dv_d;
            res_q_q   <= res_q_d;
            res_err_q <= res_err_d;
            tmo_q     <= tmo_d;
            qo_q      <= qo_d;
            dz_q      <= dz_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == RESP) begin
            ack[cur_id_q] = 1'b1;
        end
    end

    assign div_go  = (state_q == GO_HI) || (state_q == WAIT_DN);
    assign busy    = (state_q != IDLE);
    assign div_dd  = dd_q;
    assign div_dv  = dv_q;
    assign q_out   = qo_q;
    assign dz_out  = dz_q;
    assign err_out = err_q;

endmodule

// File: tb/tb_div_rr_arbiter.sv
module tb_div_rr_arbiter;

    localparam int N   = 4;
    localparam int DDW = 32;
    localparam int DVW = 16;
    localparam int QW  = 16;
    localparam int TMO = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DDW-1:0]  dd_in;
    logic [N*DVW-1:0]  dv_in;
    logic [N-1:0]      ack;
    logic [QW-1:0]     q_out;
    logic              dz_out, err_out, busy, div_go;
    logic [DDW-1:0]    div_dd;
    logic [DVW-1:0]    div_dv;
    logic              div_done = 1'b0;
    logic [QW-1:0]     div_q = '0;

    div_rr_arbiter #(.N_REQ(N), .DD_W(DDW), .DV_W(DVW), .Q_W(QW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dd_in(dd_in), .dv_in(dv_in),
        .ack(ack), .q_out(q_out), .dz_out(dz_out), .err_out(err_out), .busy(busy),
        .div_go(div_go), .div_dd(div_dd), .div_dv(div_dv), .div_done(div_done), .div_q(div_q)
    );

    // Behavioural divider: idle with done=1; on go it drops done for dm_lat cycles,
    // then raises done with the quotient and waits for go to fall before accepting again.
    int                 dm_cnt = 0;
    int                 dm_lat;
    bit                 dm_hang, dm_force;
    bit                 dm_wait_low = 1'b0;
    logic signed [31:0] dm_res = '0;
    int                 go_cycles = 0;

    always @(posedge clk) begin
        if (div_go) go_cycles <= go_cycles + 1;
        if (dm_force) begin
            div_done    <= 1'b0;
            dm_cnt      <= 0;
            dm_wait_low <= 1'b0;
        end else if (dm_cnt > 0) begin
            dm_cnt <= dm_cnt - 1;
            if (dm_cnt == 1) begin
                div_done    <= 1'b1;
                div_q       <= dm_res[QW-1:0];
                dm_wait_low <= 1'b1;
            end
        end else if (!div_done) begin
            div_done <= 1'b1;
        end else if (dm_wait_low) begin
            if (!div_go) dm_wait_low <= 1'b0;
        end else if (div_go && !dm_hang) begin
            div_done <= 1'b0;
            dm_cnt   <= dm_lat;
            dm_res   <= $signed(div_dd) / $signed({{(32-DVW){div_dv[DVW-1]}}, div_dv});
        end
    end

    // Reference model: pending set, last-served pointer, expected result per client.
    int            errors = 0;
    int            checks = 0;
    int            exp_ptr;
    bit            pend [N];
    logic [QW-1:0] exp_q [N];
    bit            exp_dz [N];
    bit            exp_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic post(input int i, input int dd, input int dv);
        logic signed [DVW-1:0] dvs;
        int t;
        dvs = DVW'(dv);
        dd_in[i*DDW +: DDW] = DDW'(dd);
        dv_in[i*DVW +: DVW] = dvs;
        exp_dz[i] = (dvs == 0);
        if (dvs == 0) begin
            exp_q[i] = '0;
        end else begin
            t = dd / int'(dvs);
            exp_q[i] = QW'(t);
        end
        pend[i] = 1'b1;
        req[i]  = 1'b1;
    endtask

    function automatic int predict();
        for (int k = 1; k <= N; k++) begin
            if (pend[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic expect_ack(input string tag, input int budget, input bit hold,
                              output int got, output int lat);
        int w, wi;
        bit seen;
        logic [N-1:0]  ev;
        logic [QW-1:0] eq;
        bit edz;
        seen = 1'b0; lat = 0; got = -1;
        while (!seen && lat < budget) begin
            tick();
            lat++;
            if (ack !== '0) seen = 1'b1;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            w  = predict();
            wi = (w < 0) ? 0 : w;
            ev = '0;
            if (w >= 0) ev[w] = 1'b1;
            for (int k = 0; k < N; k++) if (ack[k]) got = k;
            eq  = exp_err ? '0 : exp_q[wi];
            edz = exp_err ? 1'b0 : exp_dz[wi];
            check({tag, "_ack"}, 64'(ack), 64'(ev));
            check({tag, "_q"}, 64'(q_out), 64'(eq));
            check({tag, "_dz"}, 64'(dz_out), 64'(edz));
            check({tag, "_err"}, 64'(err_out), 64'(exp_err));
            if (w >= 0) begin
                exp_ptr = w;
                if (!hold) begin
                    pend[w] = 1'b0;
                    req[w]  = 1'b0;
                end
            end
            tick();
            check({tag, "_one_cycle"}, 64'(ack), 64'd0);
            check({tag, "_q_held"}, 64'(q_out), 64'(eq));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int got, lat, prev, g0, n, any;
        rst_n = 1'b0; req = '0; dd_in = '0; dv_in = '0;
        dm_force = 1'b1; dm_hang = 1'b0; dm_lat = 20;
        exp_ptr = N - 1; exp_err = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (3) tick();

        // 1: reset values; IDLE holds while the divider reports busy.
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_q", 64'(q_out), 64'd0);
        check("rst_dz", 64'(dz_out), 64'd0);
        check("rst_err", 64'(err_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_go", 64'(div_go), 64'd0);
        check("rst_dd", 64'(div_dd), 64'd0);
        check("rst_dv", 64'(div_dv), 64'd0);
        rst_n = 1'b1;
        post(0, 12345, 100);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("idle_hold_busy", 64'(busy), 64'd0);
        end
        check("idle_hold_go", 64'(div_go), 64'd0);
        dm_force = 1'b0;
        expect_ack("t1_first", 40, 1'b0, got, lat);

        // 2: single request, operands changed after grant must not matter.
        dm_lat = 20;
        g0 = go_cycles;
        post(2, 100, 7);
        repeat (3) tick();
        dd_in[2*DDW +: DDW] = 32'd999;
        dv_in[2*DVW +: DVW] = 16'd3;
        expect_ack("t2_single", 60, 1'b0, got, lat);
        check("t2_go_len", 64'((go_cycles - g0) >= dm_lat + 1), 64'd1);
        check("t2_dd_latched", 64'(div_dd), 64'd100);

        // 3: all four requesting continuously.
        dm_lat = 3;
        post(0, 1000, 10); post(1, -77, 7); post(2, 5, 9); post(3, 30000, -3);
        prev = exp_ptr;
        for (int i = 0; i < 5; i++) begin
            expect_ack("t3_cont", 40, 1'b1, got, lat);
            check("t3_no_repeat", 64'(got != prev), 64'd1);
            prev = got;
        end
        for (int i = 0; i < 4; i++) expect_ack("t3_drain", 40, 1'b0, got, lat);

        // 4: divide by zero bypasses the divider; ack right after the grant edge.
        g0 = go_cycles;
        post(1, 55, 0);
        expect_ack("t4_dz", 1, 1'b0, got, lat);
        check("t4_no_go", 64'(go_cycles), 64'(g0));

        // 5: hung divider times out; next client still served.
        dm_hang = 1'b1; exp_err = 1'b1;
        post(2, 9, 3);
        expect_ack("t5_tmo", TMO + 40, 1'b0, got, lat);
        check("t5_tmo_lat", 64'(lat >= TMO + 1 && lat <= TMO + 4), 64'd1);
        dm_hang = 1'b0; exp_err = 1'b0;
        dm_lat = 5;
        post(3, -1000, 7);
        expect_ack("t5_after", 40, 1'b0, got, lat);

        // 6: reset during WAIT_DN.
        dm_lat = 30;
        post(3, 1000, 10);
        repeat (10) tick();
        check("t6_go_before", 64'(div_go), 64'd1);
        rst_n = 1'b0; req = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        tick();
        check("t6_go_rst", 64'(div_go), 64'd0);
        check("t6_ack_rst", 64'(ack), 64'd0);
        rst_n = 1'b1;
        exp_ptr = N - 1;
        dm_lat = 4;
        post(1, -50, 5);
        n = 0;
        while (div_done == 1'b0 && n < 60) begin
            tick();
            n++;
            check("t6_wait_busy", 64'(busy), 64'd0);
            check("t6_wait_ack", 64'(ack), 64'd0);
        end
        check("t6_done_back", 64'(div_done), 64'd1);
        expect_ack("t6_after_rst", 20, 1'b0, got, lat);

        // Random traffic against the reference model.
        for (int r = 0; r < 40; r++) begin
            dm_lat = int'($urandom_range(12, 1));
            any = 0;
            for (int i = 0; i < N; i++) begin
                if (pend[i]) any = 1;
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    post(i, int'($urandom_range(200000, 0)) - 100000,
                         ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(600, 1)) - 300);
                    any = 1;
                end
            end
            if (any == 0) post(int'($urandom_range(N - 1, 0)), 4242, 21);
            expect_ack("rnd", 60, 1'b0, got, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
